motor_mixer: RTL and testbench

Parametrised, sequential motor mixer for the flight controller. Each frame it takes raw SBUS/FPort channel values from the RC decoder and a runtime-loadable signed coefficient table, and computes one DShot command per motor with a single time-shared multiply-accumulate. It saturates each result to the DShot throttle range and hands the commands to the `motor_control` instances with a one-cycle valid strobe. It sits between `fport_rx_decoder` and the motor outputs, triggered by the motor update tick.

---
 rtl/motor_mixer.sv | 222 ++++++++++++++++++++++
 tb/tb_motor_mixer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/motor_mixer.sv
// motor_mixer: per-frame motor mixer built around one time-shared signed MAC.
// Scales raw RC channels, mixes them through a loadable coefficient table,
// then clamps each motor to the DShot throttle range.
// Optional build macro: MOTOR_MIXER_DESAT_EN adds a desaturation cycle that
// shifts all motors down when the highest one exceeds OUT_MAX.
module motor_mixer #(
    parameter int unsigned MOTOR_COUNT = 4,
    parameter int unsigned INPUT_COUNT = 4,
    parameter int unsigned COEF_WIDTH  = 8,
    parameter int unsigned COEF_FRAC   = 6,
    parameter int          OUT_MIN     = 48,
    parameter int          OUT_MAX     = 2047,
    localparam int unsigned COEF_N     = MOTOR_COUNT * INPUT_COUNT,
    localparam int unsigned ADDR_W     = (COEF_N > 1) ? $clog2(COEF_N) : 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic                           i_armed,
    input  logic                           i_failsafe,
    input  logic [INPUT_COUNT*11-1:0]      i_ctrl_in,
    input  logic                           i_coef_we,
    input  logic [ADDR_W-1:0]              i_coef_addr,
    input  logic signed [COEF_WIDTH-1:0]   i_coef_data,
    output logic                           o_busy,
    output logic                           o_valid,
    output logic [MOTOR_COUNT*11-1:0]      o_motor_out
);

    localparam int unsigned IDX_W = ADDR_W;
    localparam int unsigned INP_W = $clog2(INPUT_COUNT);
    localparam int unsigned MOT_W = (MOTOR_COUNT > 1) ? $clog2(MOTOR_COUNT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCALE,
        S_MAC,
`ifdef MOTOR_MIXER_DESAT_EN
        S_DESAT,
`endif
        S_FINAL
    } state_t;

    state_t                         r_state;
    logic                           r_busy;
    logic                           r_valid;
    logic                           r_armed;
    logic                           r_failsafe;
    logic [INPUT_COUNT*11-1:0]      r_ctrl;
    logic [MOTOR_COUNT*11-1:0]      r_motor_out;
    logic signed [COEF_WIDTH-1:0]   r_coef [COEF_N];
    logic signed [31:0]             r_term [INPUT_COUNT];
    logic signed [31:0]             r_raw  [MOTOR_COUNT];
    logic signed [31:0]             r_acc;
    logic [IDX_W-1:0]               r_idx;
    logic [INP_W-1:0]               r_inp;
    logic [MOT_W-1:0]               r_mot;

    logic signed [31:0]             w_rsc  [INPUT_COUNT];
    logic signed [31:0]             w_term [INPUT_COUNT];
    logic signed [31:0]             w_prod;
    logic signed [31:0]             w_acc_next;
    logic signed [31:0]             w_raw_new;
    logic [MOTOR_COUNT*11-1:0]      w_clamped;
    logic                           w_coef_wr;
`ifdef MOTOR_MIXER_DESAT_EN
    logic signed [31:0]             w_raw_max;
    logic signed [31:0]             w_excess;
`endif

    // Quad-X reset table: +1.0 throttle, signed roll/pitch/yaw per motor
    function automatic logic signed [COEF_WIDTH-1:0] default_coef(input int m, input int i);
        int v;
        v = 0;
        if (m < 4 && i < 4) begin
            v = 64;
            case (i)
                1:       if (m >= 2) v = -64;
                2:       if (m == 0 || m == 2) v = -64;
                3:       if (m == 0 || m == 3) v = -64;
                default: v = 64;
            endcase
        end
        return COEF_WIDTH'(v);
    endfunction

    // Channel scaling: R = (5x/8 - 620)*4, throttle re-biased to 0..1000
    always_comb begin
        for (int i = 0; i < INPUT_COUNT; i++) begin
            w_rsc[INP_W'(i)] = (signed'((32'(r_ctrl[11*i +: 11]) * 32'd5) >> 3) - 32'sd620) * 32'sd4;
            w_term[INP_W'(i)] = w_rsc[INP_W'(i)];
        end
        // R0 is always a multiple of 4, so the arithmetic shift is an exact /4
        w_term[0] = (w_rsc[0] + 32'sd2000) >>> 2;
    end

    // Single multiply-accumulate step and the per-motor rescale
    always_comb begin
        w_prod     = 32'(r_coef[r_idx]) * r_term[r_inp];
        w_acc_next = r_acc + w_prod;
        w_raw_new  = (w_acc_next >>> COEF_FRAC) + OUT_MIN;
    end

    // Saturate each raw motor value into the DShot throttle window
    always_comb begin
        w_clamped = '0;
        for (int m = 0; m < MOTOR_COUNT; m++) begin
            if (r_raw[MOT_W'(m)] < OUT_MIN)
                w_clamped[11*m +: 11] = 11'(OUT_MIN);
            else if (r_raw[MOT_W'(m)] > OUT_MAX)
                w_clamped[11*m +: 11] = 11'(OUT_MAX);
            else
                w_clamped[11*m +: 11] = 11'(r_raw[MOT_W'(m)]);
        end
    end

`ifdef MOTOR_MIXER_DESAT_EN
    // Largest motor demand and how far it overshoots the ceiling
    always_comb begin
        w_raw_max = r_raw[0];
        for (int m = 1; m < MOTOR_COUNT; m++) begin
            if (r_raw[MOT_W'(m)] > w_raw_max) w_raw_max = r_raw[MOT_W'(m)];
        end
        w_excess = w_raw_max - OUT_MAX;
    end
`endif

    // Table writes only land when idle and inside the table
    always_comb begin
        w_coef_wr = i_coef_we && (32'(i_coef_addr) < COEF_N);
    end

    // Frame sequencer, coefficient table and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_armed     <= 1'b0;
            r_failsafe  <= 1'b0;
            r_ctrl      <= '0;
            r_motor_out <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_inp       <= '0;
            r_mot       <= '0;
            for (int k = 0; k < COEF_N; k++)
                r_coef[IDX_W'(k)] <= default_coef(int'(k / INPUT_COUNT), int'(k % INPUT_COUNT));
            for (int i = 0; i < INPUT_COUNT; i++)
                r_term[INP_W'(i)] <= '0;
            for (int m = 0; m < MOTOR_COUNT; m++)
                r_raw[MOT_W'(m)] <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_busy) begin
                        // Valid cycle of the previous frame: requests are ignored
                        r_busy <= 1'b0;
                    end else begin
                        if (w_coef_wr) r_coef[i_coef_addr] <= i_coef_data;
                        if (i_start) begin
                            r_ctrl     <= i_ctrl_in;
                            r_armed    <= i_armed;
                            r_failsafe <= i_failsafe;
                            r_busy     <= 1'b1;
                            r_state    <= S_SCALE;
                        end
                    end
                end
                S_SCALE: begin
                    for (int i = 0; i < INPUT_COUNT; i++)
                        r_term[INP_W'(i)] <= w_term[INP_W'(i)];
                    r_acc   <= '0;
                    r_idx   <= '0;
                    r_inp   <= '0;
                    r_mot   <= '0;
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    r_idx <= r_idx + IDX_W'(1);
                    if (r_inp == INP_W'(INPUT_COUNT - 1)) begin
                        r_raw[r_mot] <= w_raw_new;
                        r_acc        <= '0;
                        r_inp        <= '0;
                        r_mot        <= r_mot + MOT_W'(1);
                        if (r_idx == IDX_W'(COEF_N - 1)) begin
`ifdef MOTOR_MIXER_DESAT_EN
                            r_state <= S_DESAT;
`else
                            r_state <= S_FINAL;
`endif
                        end
                    end else begin
                        r_acc <= w_acc_next;
                        r_inp <= r_inp + INP_W'(1);
                    end
                end
`ifdef MOTOR_MIXER_DESAT_EN
                S_DESAT: begin
                    if (w_excess > 0) begin
                        for (int m = 0; m < MOTOR_COUNT; m++)
                            r_raw[MOT_W'(m)] <= r_raw[MOT_W'(m)] - w_excess;
                    end
                    r_state <= S_FINAL;
                end
`endif
                S_FINAL: begin
                    r_motor_out <= (r_armed && !r_failsafe) ? w_clamped : '0;
                    r_valid     <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_valid     = r_valid;
    assign o_motor_out = r_motor_out;

endmodule

// File: tb/tb_motor_mixer.sv
// tb_motor_mixer: directed vector table plus hand sequences for the
// valid/start handshake, coefficient loads and mid-frame reset.
`timescale 1ns/1ps
module tb_motor_mixer;

`ifdef MOTOR_MIXER_DESAT_EN
    localparam int LAT = 19;
`else
    localparam int LAT = 18;
`endif
    localparam int NV = 10;
    localparam logic [43:0] HOVER = {4{11'd992}};

    typedef struct packed {
        logic             armed;
        logic             fs;
        logic [3:0][10:0] ch;
        logic [3:0][10:0] exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        armed;
    logic        failsafe;
    logic [43:0] ctrl_in;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [7:0]  coef_data;
    logic        busy;
    logic        valid;
    logic [43:0] motor_out;

    int n_chk;
    int n_pass;
    vec_t vecs [NV];

    motor_mixer dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_armed     (armed),
        .i_failsafe  (failsafe),
        .i_ctrl_in   (ctrl_in),
        .i_coef_we   (coef_we),
        .i_coef_addr (coef_addr),
        .i_coef_data (coef_data),
        .o_busy      (busy),
        .o_valid     (valid),
        .o_motor_out (motor_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic a, input logic f,
                                input int c0, input int c1, input int c2, input int c3,
                                input int e0, input int e1, input int e2, input int e3);
        vec_t v;
        v.armed  = a;
        v.fs     = f;
        v.ch[0]  = 11'(c0);
        v.ch[1]  = 11'(c1);
        v.ch[2]  = 11'(c2);
        v.ch[3]  = 11'(c3);
        v.exp[0] = 11'(e0);
        v.exp[1] = 11'(e1);
        v.exp[2] = 11'(e2);
        v.exp[3] = 11'(e3);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, req);
    endtask

    function automatic int mout(input int m);
        return int'(motor_out[11*m +: 11]);
    endfunction

    // Wait for valid after a sampled start; -1 if it never arrives
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_frame(input logic a, input logic f, input logic [43:0] ctrl,
                             input logic we, input logic [3:0] addr, input logic [7:0] data,
                             output int lat);
        @(negedge clk);
        armed = a; failsafe = f; ctrl_in = ctrl; start = 1'b1;
        coef_we = we; coef_addr = addr; coef_data = data;
        @(posedge clk); #1;
        start = 1'b0; coef_we = 1'b0;
        wait_valid(lat);
    endtask

    initial begin
        int lat;
        int seen;
        n_chk = 0; n_pass = 0;
        rst = 1'b1; start = 1'b0; armed = 1'b0; failsafe = 1'b0;
        ctrl_in = '0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;

        vecs[0] = mk(1, 0,  992,  992,  992,  992,   548,  548,  548,  548);
        vecs[1] = mk(1, 0,  992, 1792,  992,  992,  2047, 2047,   48,   48);
        vecs[2] = mk(1, 0,  992, 1200,  992,  992,  1068, 1068,   48,   48);
        vecs[3] = mk(0, 0,  992,  992,  992,  992,     0,    0,    0,    0);
        vecs[4] = mk(1, 1, 1792,  992,  992,  992,     0,    0,    0,    0);
        vecs[5] = mk(1, 0,  992,  992, 1792,  992,    48, 2047,   48, 2047);
        vecs[6] = mk(1, 0,  992,  992,  992, 1100,   280,  816,  816,  280);
        vecs[7] = mk(1, 0,    0,  992,  992,  992,    48,   48,   48,   48);
        vecs[8] = mk(1, 0, 2047,  992,  992,  992,  1207, 1207, 1207, 1207);
        vecs[9] = mk(1, 0, 1500, 1000,  900, 1200,   597, 1173, 1597,   93);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_motor_out_nonzero", int'(motor_out != '0), 0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);

        // Vector table
        for (int k = 0; k < NV; k++) begin
            run_frame(vecs[k].armed, vecs[k].fs, vecs[k].ch, 1'b0, 4'd0, 8'd0, lat);
            check($sformatf("v%0d_latency", k), lat, LAT);
            for (int m = 0; m < 4; m++)
                check($sformatf("v%0d_m%0d", k, m), mout(m), int'(vecs[k].exp[m]));
            @(posedge clk); #1;
            check($sformatf("v%0d_valid_one_cycle", k), int'(valid), 0);
            check($sformatf("v%0d_busy_dropped", k), int'(busy), 0);
        end

        // Start during the valid cycle is ignored, start one cycle later is taken
        @(negedge clk);
        armed = 1'b1; failsafe = 1'b0; ctrl_in = HOVER; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        wait_valid(lat);
        check("hs_latency", lat, LAT);
        check("busy_in_valid_cycle", int'(busy), 1);
        start = 1'b1;
        @(posedge clk); #1;
        check("start_in_valid_cycle_ignored", int'(busy), 0);
        check("valid_after_pulse", int'(valid), 0);
        @(posedge clk); #1;
        start = 1'b0;
        check("start_after_valid_accepted", int'(busy), 1);
        wait_valid(lat);
        check("hs2_latency", lat, LAT);
        check("hs2_m0", mout(0), 548);
        repeat (6) @(posedge clk);
        #1;
        check("motor_out_hold", mout(3), 548);

        // Coefficient load in idle
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'd32;
        @(posedge clk); #1;
        coef_we = 1'b0;
        run_frame(1'b1, 1'b0, HOVER, 1'b0, 4'd0, 8'd0, lat);
        check("coef32_m0", mout(0), 298);
        check("coef32_m1", mout(1), 548);
        @(posedge clk); #1;

        // Write while busy must be dropped
        @(negedge clk);
        ctrl_in = HOVER; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'd64;
        @(posedge clk); #1;
        coef_we = 1'b0;
        wait_valid(lat);
        @(posedge clk); #1;
        run_frame(1'b1, 1'b0, HOVER, 1'b0, 4'd0, 8'd0, lat);
        check("busy_write_ignored_m0", mout(0), 298);
        @(posedge clk); #1;

        // Write coincident with start is used by that frame
        run_frame(1'b1, 1'b0, HOVER, 1'b1, 4'd0, 8'd0, lat);
        check("coincident_write_m0", mout(0), 48);
        check("coincident_write_m2", mout(2), 548);
        @(posedge clk); #1;

        // Async reset in the middle of MAC
        @(negedge clk);
        ctrl_in = HOVER; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_motor_out_nonzero", int'(motor_out != '0), 0);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (valid) seen = 1;
        end
        check("midrst_no_valid", seen, 0);
        run_frame(1'b1, 1'b0, HOVER, 1'b0, 4'd0, 8'd0, lat);
        check("post_rst_latency", lat, LAT);
        for (int m = 0; m < 4; m++)
            check($sformatf("post_rst_m%0d", m), mout(m), 548);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
